iob_axistream_in: RTL and testbench
===================================

IOB_AXISTREAM_IN -- requirements
Module: iob_axistream_in

Interface
REQ-001 The block SHALL have these parameters:
- DATA_W, 32: CPU data width.
- ADDR_W, 2: CPU word-address width.
- FIFO_DEPTH_LOG2, 4: log2 of FIFO depth.
REQ-002 The block SHALL have these ports, one clock and reset is asynchronous and active-low:
- clk  in  1  clock; all logic on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- valid  in  1  CPU request.
- address  in  ADDR_W  CPU word address.
- wdata  in  DATA_W  CPU write data.
- wstrb  in  DATA_W/8  write strobes; any bit set means write, all zero means read.
- rdata  out  DATA_W  CPU read data.
- ready  out  1  CPU response.
- tdata  in  8  stream data.
- tvalid  in  1  stream valid.
- tready  out  1  stream ready.
- tlast  in  1  stream end-of-frame.

Function
REQ-003 Register map (word addresses), SHALL be:
- 0 DATA, R: {23'b0, tlast, tdata} of the FIFO head; a read pops the FIFO.
- 1 EMPTY, R: bit0 = FIFO empty.
- 2 LEVEL, R: FIFO occupancy, 0..2^FIFO_DEPTH_LOG2.
- 3 SOFTRST, W: writing 1 to bit0 flushes the FIFO.
REQ-004 A beat SHALL be accepted on every rising edge with tvalid & tready; it is stored as the 9-bit word {tlast, tdata} in a first-word-fall-through FIFO of depth 2^FIFO_DEPTH_LOG2.
REQ-005 tready SHALL be registered and equal ~full for the next cycle's occupancy; it SHALL never be high while the FIFO holds 2^FIFO_DEPTH_LOG2 words.
REQ-006 ready SHALL assert exactly one cycle after valid, for one cycle; rdata SHALL be valid in that cycle and 0 otherwise.
REQ-007 A DATA read while empty SHALL return 0, SHALL not pop, and SHALL not change LEVEL.
REQ-008 A simultaneous pop and push SHALL leave LEVEL unchanged and preserve order.
REQ-009 FIFO read and write pointers SHALL wrap modulo 2^FIFO_DEPTH_LOG2; LEVEL SHALL use FIFO_DEPTH_LOG2+1 bits.
REQ-010 A SOFTRST write SHALL zero pointers and LEVEL on the following edge.
REQ-011 A beat presented in the same cycle as a SOFTRST write SHALL be discarded.
REQ-012 Writes to addresses 0..2 and reads of address 3 SHALL be acknowledged with ready; reads of address 3 SHALL return 0, and these accesses SHALL have no side effect.

Reset
REQ-013 While rst_n = 0, the block SHALL hold:
- tready = 0, ready = 0, rdata = 0.
- FIFO empty, LEVEL = 0.
- frame-hold flag (REQ-015) clear.
REQ-014 tready SHALL rise on the first clock edge after rst_n deasserts; a reset mid-frame SHALL drop all buffered beats.

Configuration
REQ-015 With macro AXISTREAMIN_FRAME_HOLD_EN defined:
- Accepting a beat with tlast = 1 SHALL set a hold flag that forces tready = 0 from the next cycle.
- The CPU read that pops that tlast word SHALL clear the flag, so at most one frame is buffered.
- EMPTY bit1 SHALL read the hold flag.
REQ-016 Without AXISTREAMIN_FRAME_HOLD_EN, tlast SHALL only be stored, tready SHALL depend on full only, and EMPTY bit1 SHALL read 0.

Verification
REQ-017 Basic path: send beats 0x11, 0x22, 0x33 (tlast on 0x33), then read DATA three times -> 0x011, 0x022, 0x133; EMPTY then reads 1 and LEVEL reads 0.
REQ-018 Full: hold tvalid = 1 with FIFO_DEPTH_LOG2 = 4 -> exactly 16 beats accepted, tready low while full, LEVEL = 16; one DATA read -> tready high one cycle later and the 17th beat is accepted.
REQ-019 Empty read: read DATA after reset -> rdata = 0, ready one cycle after valid, LEVEL stays 0.
REQ-020 Concurrent: pop while a beat is accepted at LEVEL = 5 -> LEVEL stays 5 and data order is preserved across pointer wrap after 40 beats.
REQ-021 Flush and reset: write SOFTRST = 1 at LEVEL = 7 -> LEVEL 0, EMPTY 1; assert rst_n low mid-frame -> tready 0 immediately, FIFO empty after release.
REQ-022 Frame hold, with macro defined: send a frame of 4 beats followed by a second frame -> tready low after the tlast beat, EMPTY bit1 = 1; the fourth DATA read reopens tready.

Source files
------------

// File: rtl/iob_axistream_in.sv
// iob_axistream_in: AXI-Stream byte sink buffered in a first-word-fall-through
// FIFO and drained by a simple valid/ready CPU register interface.
// Optional feature: define AXISTREAMIN_FRAME_HOLD_EN to stall the stream after
// a tlast beat until the CPU has popped that beat, so at most one frame is buffered.
module iob_axistream_in #(
  parameter int DATA_W          = 32,
  parameter int ADDR_W          = 2,
  parameter int FIFO_DEPTH_LOG2 = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                valid,
  input  logic [ADDR_W-1:0]   address,
  input  logic [DATA_W-1:0]   wdata,
  input  logic [DATA_W/8-1:0] wstrb,
  output logic [DATA_W-1:0]   rdata,
  output logic                ready,
  input  logic [7:0]          tdata,
  input  logic                tvalid,
  output logic                tready,
  input  logic                tlast
);

  localparam int unsigned DEPTH = 2 ** FIFO_DEPTH_LOG2;
  localparam logic [FIFO_DEPTH_LOG2:0] LEVEL_FULL = {1'b1, {FIFO_DEPTH_LOG2{1'b0}}};

  typedef enum logic [ADDR_W-1:0] {
    REG_DATA    = ADDR_W'(0),
    REG_EMPTY   = ADDR_W'(1),
    REG_LEVEL   = ADDR_W'(2),
    REG_SOFTRST = ADDR_W'(3)
  } reg_addr_e;

  logic [8:0]                 mem_q [DEPTH];
  logic [FIFO_DEPTH_LOG2-1:0] wptr_q, wptr_d;
  logic [FIFO_DEPTH_LOG2-1:0] rptr_q, rptr_d;
  logic [FIFO_DEPTH_LOG2:0]   level_q, level_d;
  logic                       tready_q, tready_d;
  logic                       ready_q;
  logic [DATA_W-1:0]          rdata_q, rdata_d;
  logic                       hold_q, hold_d;

  logic       wr_req, rd_req;
  logic       empty, flush, push, pop;
  logic [8:0] head;
  logic       unused_wdata;

  // Only bit0 of the write data carries meaning (SOFTRST).
  assign unused_wdata = ^wdata[DATA_W-1:1];

  assign tready = tready_q;
  assign ready  = ready_q;
  assign rdata  = rdata_q;

  // Request decode and FIFO push/pop qualification; a flush swallows a concurrent beat.
  always_comb begin
    wr_req = valid & (|wstrb);
    rd_req = valid & ~(|wstrb);
    empty  = (level_q == '0);
    head   = mem_q[rptr_q];
    flush  = wr_req && (address == REG_SOFTRST) && wdata[0];
    push   = tvalid && tready_q && !flush;
    pop    = rd_req && (address == REG_DATA) && !empty;
  end

  // Read mux; anything that is not a recognised read returns zero.
  always_comb begin
    rdata_d = '0;
    if (rd_req) begin
      case (address)
        REG_DATA:  if (!empty) rdata_d = DATA_W'(head);
        REG_EMPTY: rdata_d = DATA_W'({hold_q, empty});
        REG_LEVEL: rdata_d = DATA_W'(level_q);
        default:   rdata_d = '0;
      endcase
    end
  end

  // Pointer and occupancy update; push and pop together leave LEVEL unchanged.
  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    level_d = level_q;
    if (flush) begin
      wptr_d  = '0;
      rptr_d  = '0;
      level_d = '0;
    end else begin
      if (push) wptr_d = wptr_q + 1'b1;
      if (pop)  rptr_d = rptr_q + 1'b1;
      case ({push, pop})
        2'b10:   level_d = level_q + 1'b1;
        2'b01:   level_d = level_q - 1'b1;
        default: level_d = level_q;
      endcase
    end
  end

`ifdef AXISTREAMIN_FRAME_HOLD_EN
  // Frame-hold flag: set by an accepted tlast beat, cleared when that beat is popped.
  always_comb begin
    hold_d = hold_q;
    if (flush)                 hold_d = 1'b0;
    else if (push && tlast)    hold_d = 1'b1;
    else if (pop && head[8])   hold_d = 1'b0;
    tready_d = (level_d != LEVEL_FULL) && !hold_d;
  end
`else
  // Without frame hold, tready follows next-cycle fullness only.
  always_comb begin
    hold_d   = 1'b0;
    tready_d = (level_d != LEVEL_FULL);
  end
`endif

  // FIFO storage; contents need no reset since LEVEL gates every read.
  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q] <= {tlast, tdata};
  end

  // Pointers, occupancy, stream handshake and CPU response registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q   <= '0;
      rptr_q   <= '0;
      level_q  <= '0;
      tready_q <= 1'b0;
      ready_q  <= 1'b0;
      rdata_q  <= '0;
      hold_q   <= 1'b0;
    end else begin
      wptr_q   <= wptr_d;
      rptr_q   <= rptr_d;
      level_q  <= level_d;
      tready_q <= tready_d;
      ready_q  <= valid;
      rdata_q  <= rdata_d;
      hold_q   <= hold_d;
    end
  end

endmodule

// File: tb/tb_iob_axistream_in.sv
module tb_iob_axistream_in;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 2;
  localparam int FLOG2  = 4;

  logic                clk     = 1'b0;
  logic                rst_n   = 1'b0;
  logic                valid   = 1'b0;
  logic [ADDR_W-1:0]   address = '0;
  logic [DATA_W-1:0]   wdata   = '0;
  logic [DATA_W/8-1:0] wstrb   = '0;
  logic [DATA_W-1:0]   rdata;
  logic                ready;
  logic [7:0]          tdata   = '0;
  logic                tvalid  = 1'b0;
  logic                tready;
  logic                tlast   = 1'b0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  iob_axistream_in #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W),
    .FIFO_DEPTH_LOG2(FLOG2)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .valid(valid),
    .address(address),
    .wdata(wdata),
    .wstrb(wstrb),
    .rdata(rdata),
    .ready(ready),
    .tdata(tdata),
    .tvalid(tvalid),
    .tready(tready),
    .tlast(tlast)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One CPU access starting just after a rising edge; returns just after a rising edge.
  task automatic cpu(input logic [1:0] addr, input logic wr, input logic [31:0] wd,
                     output logic [31:0] rd);
    valid   = 1'b1;
    address = addr;
    wdata   = wd;
    wstrb   = wr ? 4'hF : 4'h0;
    @(negedge clk);
    chk("ready_before_ack", 32'(ready), 32'd0);
    @(posedge clk); #1;
    valid = 1'b0;
    wstrb = '0;
    @(negedge clk);
    chk("ready_ack", 32'(ready), 32'd1);
    rd = rdata;
    @(posedge clk); #1;
    chk("ready_one_cycle", 32'(ready), 32'd0);
    chk("rdata_idle_zero", rdata, 32'd0);
  endtask

  task automatic cpu_rd(input logic [1:0] addr, input logic [31:0] exp, input string tag);
    logic [31:0] rd;
    cpu(addr, 1'b0, 32'd0, rd);
    chk(tag, rd, exp);
  endtask

  task automatic cpu_wr(input logic [1:0] addr, input logic [31:0] wd);
    logic [31:0] rd;
    cpu(addr, 1'b1, wd, rd);
  endtask

  task automatic send_beat(input logic [7:0] d, input logic last);
    logic ok;
    ok     = 1'b0;
    tvalid = 1'b1;
    tdata  = d;
    tlast  = last;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      if (tready === 1'b1) ok = 1'b1;
      @(posedge clk); #1;
    end
    tvalid = 1'b0;
    tlast  = 1'b0;
    chk("beat_accepted", 32'(ok), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int cnt;
    logic acc;

    // Reset state and tready rising on the first edge after release.
    repeat (2) @(posedge clk);
    #1;
    chk("rst_tready", 32'(tready), 32'd0);
    chk("rst_ready", 32'(ready), 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("tready_before_first_edge", 32'(tready), 32'd0);
    @(posedge clk); #1;
    chk("tready_after_first_edge", 32'(tready), 32'd1);

    // Empty read.
    cpu_rd(2'd0, 32'h0, "empty_data_read");
    cpu_rd(2'd2, 32'h0, "empty_level");
    cpu_rd(2'd1, 32'h1, "empty_flag");

    // Basic path.
    send_beat(8'h11, 1'b0);
    send_beat(8'h22, 1'b0);
    send_beat(8'h33, 1'b1);
    cpu_rd(2'd2, 32'h3, "basic_level3");
`ifdef AXISTREAMIN_FRAME_HOLD_EN
    cpu_rd(2'd1, 32'h2, "basic_empty_hold");
`else
    cpu_rd(2'd1, 32'h0, "basic_empty_nohold");
`endif
    cpu_rd(2'd0, 32'h011, "basic_d0");
    cpu_rd(2'd0, 32'h022, "basic_d1");
    cpu_rd(2'd0, 32'h133, "basic_d2");
    cpu_rd(2'd1, 32'h1, "basic_empty_after");
    cpu_rd(2'd2, 32'h0, "basic_level_after");

    // Side-effect-free accesses.
    send_beat(8'h44, 1'b0);
    cpu_wr(2'd0, 32'hFFFF_FFFF);
    cpu_wr(2'd1, 32'hFFFF_FFFF);
    cpu_wr(2'd2, 32'hFFFF_FFFF);
    cpu_rd(2'd3, 32'h0, "softrst_read_zero");
    cpu_rd(2'd2, 32'h1, "noeffect_level");
    cpu_rd(2'd0, 32'h044, "noeffect_data");

    // Full: hold tvalid high with incrementing data.
    tvalid = 1'b1;
    tdata  = 8'd0;
    cnt    = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      acc = (tready === 1'b1);
      @(posedge clk); #1;
      if (acc) begin
        cnt++;
        tdata = 8'(cnt);
      end
    end
    chk("full_beat_count", 32'(cnt), 32'd16);
    chk("full_tready_low", 32'(tready), 32'd0);
    cpu_rd(2'd2, 32'd16, "full_level16");
    valid   = 1'b1;
    address = 2'd0;
    wstrb   = '0;
    @(negedge clk);
    chk("full_tready_before_pop", 32'(tready), 32'd0);
    @(posedge clk); #1;
    valid = 1'b0;
    @(negedge clk);
    chk("full_pop_ack", 32'(ready), 32'd1);
    chk("full_pop_data", rdata, 32'h000);
    chk("full_tready_reopen", 32'(tready), 32'd1);
    @(posedge clk); #1;
    chk("full_beat17_refull", 32'(tready), 32'd0);
    tvalid = 1'b0;
    cpu_rd(2'd2, 32'd16, "full_level_after17");
    for (int i = 1; i <= 16; i++) cpu_rd(2'd0, 32'(i), "full_drain_order");
    cpu_rd(2'd2, 32'd0, "full_drained_level");

    // Concurrent pop and push at LEVEL 5, 40 beats through the 16-deep FIFO.
    for (int n = 0; n < 5; n++) send_beat(8'(8'h40 + n), 1'b0);
    cpu_rd(2'd2, 32'd5, "conc_level_start");
    for (int k = 0; k < 35; k++) begin
      tvalid  = 1'b1;
      tdata   = 8'(8'h45 + k);
      valid   = 1'b1;
      address = 2'd0;
      wstrb   = '0;
      @(negedge clk);
      chk("conc_tready", 32'(tready), 32'd1);
      @(posedge clk); #1;
      valid  = 1'b0;
      tvalid = 1'b0;
      @(negedge clk);
      chk("conc_data", rdata, 32'(8'h40 + k));
      @(posedge clk); #1;
    end
    cpu_rd(2'd2, 32'd5, "conc_level_end");
    for (int k = 35; k < 40; k++) cpu_rd(2'd0, 32'(8'h40 + k), "conc_tail");

    // Flush at LEVEL 7 with a colliding beat.
    for (int n = 0; n < 7; n++) send_beat(8'(n + 1), 1'b0);
    cpu_rd(2'd2, 32'd7, "flush_level7");
    cpu_wr(2'd3, 32'h0);
    cpu_rd(2'd2, 32'd7, "softrst_bit0_clear_noop");
    tvalid  = 1'b1;
    tdata   = 8'h99;
    valid   = 1'b1;
    address = 2'd3;
    wstrb   = 4'hF;
    wdata   = 32'h1;
    @(posedge clk); #1;
    valid  = 1'b0;
    wstrb  = '0;
    tvalid = 1'b0;
    @(negedge clk);
    chk("flush_ack", 32'(ready), 32'd1);
    @(posedge clk); #1;
    cpu_rd(2'd2, 32'd0, "flush_level0");
    cpu_rd(2'd1, 32'd1, "flush_empty");
    cpu_rd(2'd0, 32'd0, "flush_data_dropped");
    send_beat(8'h55, 1'b0);
    cpu_rd(2'd0, 32'h055, "post_flush_data");

    // Reset mid-frame.
    send_beat(8'h61, 1'b0);
    send_beat(8'h62, 1'b0);
    send_beat(8'h63, 1'b0);
    #3;
    rst_n = 1'b0;
    #1;
    chk("midrst_tready", 32'(tready), 32'd0);
    chk("midrst_ready", 32'(ready), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("midrst_tready_held", 32'(tready), 32'd0);
    @(posedge clk); #1;
    chk("midrst_tready_rise", 32'(tready), 32'd1);
    cpu_rd(2'd2, 32'd0, "midrst_level");
    cpu_rd(2'd1, 32'd1, "midrst_empty");

`ifdef AXISTREAMIN_FRAME_HOLD_EN
    // Frame hold: second frame waits until the tlast beat is popped.
    send_beat(8'h01, 1'b0);
    send_beat(8'h02, 1'b0);
    send_beat(8'h03, 1'b0);
    send_beat(8'h04, 1'b1);
    @(negedge clk);
    chk("hold_tready_low", 32'(tready), 32'd0);
    @(posedge clk); #1;
    cpu_rd(2'd1, 32'h2, "hold_empty_bit1");
    tvalid = 1'b1;
    tdata  = 8'h05;
    tlast  = 1'b0;
    cpu_rd(2'd0, 32'h001, "hold_d0");
    cpu_rd(2'd0, 32'h002, "hold_d1");
    cpu_rd(2'd0, 32'h003, "hold_d2");
    chk("hold_still_closed", 32'(tready), 32'd0);
    valid   = 1'b1;
    address = 2'd0;
    wstrb   = '0;
    @(posedge clk); #1;
    valid = 1'b0;
    @(negedge clk);
    chk("hold_d3_last", rdata, 32'h104);
    chk("hold_reopen", 32'(tready), 32'd1);
    @(posedge clk); #1;
    tvalid = 1'b0;
    cpu_rd(2'd2, 32'd1, "hold_frame2_level");
    cpu_rd(2'd0, 32'h005, "hold_frame2_data");
    cpu_rd(2'd1, 32'h1, "hold_cleared_empty");
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
